// File: rtl/pmt_pulse_gen.sv
// Synthetic PMT pulse source: programmable bursts of fixed-width pulses,
// optionally thinned by a 16-bit Galois LFSR to mimic random photon arrivals.
module pmt_pulse_gen #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        wHClk_i,
    input  logic        wRst_i,
    input  logic        wStart_i,
    input  logic        wAbort_i,
    input  logic [31:0] wPulseNum_i,
    input  logic [31:0] wPeriod_i,
    input  logic [7:0]  wWidth_i,
    input  logic        wRandEn_i,
    input  logic [15:0] wProb_i,
    output logic        wPmt_o,
    output logic        wBusy_o,
    output logic        wDone_o,
    output logic [31:0] wSentCnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t      state, stateNxt;
    logic [31:0] slotCnt, slotCntNxt;
    logic [31:0] tickCnt, tickCntNxt;
    logic [31:0] numReg, numRegNxt;
    logic [31:0] perReg, perRegNxt;
    logic [31:0] widReg, widRegNxt;
    logic        randReg, randRegNxt;
    logic [15:0] probReg, probRegNxt;
    logic [15:0] lfsr, lfsrNxt;
    logic        pmt, pmtNxt;
    logic        busy, busyNxt;
    logic        done, doneNxt;
    logic [31:0] sent, sentNxt;

    logic [7:0]  wEff;
    logic [31:0] wEff32;
    logic [31:0] pEff;
    logic [15:0] lfsrStep;
    logic        fireStart;
    logic        fireNext;

    // Effective width/period clamping and per-slot fire decisions
    always_comb begin
        wEff      = (wWidth_i == 8'd0) ? 8'd1 : wWidth_i;
        wEff32    = {24'd0, wEff};
        pEff      = (wPeriod_i > wEff32) ? wPeriod_i : (wEff32 + 32'd1);
        lfsrStep  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        fireStart = !wRandEn_i || (lfsr <= wProb_i);
        fireNext  = !randReg || (lfsr <= probReg);
    end

    // Next-state and output logic of the burst sequencer
    always_comb begin
        stateNxt   = state;
        slotCntNxt = slotCnt;
        tickCntNxt = tickCnt;
        numRegNxt  = numReg;
        perRegNxt  = perReg;
        widRegNxt  = widReg;
        randRegNxt = randReg;
        probRegNxt = probReg;
        lfsrNxt    = lfsr;
        pmtNxt     = pmt;
        busyNxt    = busy;
        doneNxt    = 1'b0;
        sentNxt    = sent;
        unique case (state)
            IDLE: begin
                if (!wAbort_i && wStart_i && (wPulseNum_i != 32'd0)) begin
                    numRegNxt  = wPulseNum_i;
                    perRegNxt  = pEff;
                    widRegNxt  = wEff32;
                    randRegNxt = wRandEn_i;
                    probRegNxt = wProb_i;
                    slotCntNxt = 32'd0;
                    tickCntNxt = 32'd0;
                    lfsrNxt    = lfsrStep;
                    pmtNxt     = fireStart;
                    sentNxt    = {31'd0, fireStart};
                    busyNxt    = 1'b1;
                    stateNxt   = fireStart ? HIGH : LOW;
                end
            end
            HIGH, LOW: begin
                if (wAbort_i) begin
                    pmtNxt   = 1'b0;
                    busyNxt  = 1'b0;
                    stateNxt = IDLE;
                end else if (tickCnt == perReg - 32'd1) begin
                    if (slotCnt == numReg - 32'd1) begin
                        pmtNxt   = 1'b0;
                        busyNxt  = 1'b0;
                        doneNxt  = 1'b1;
                        stateNxt = IDLE;
                    end else begin
                        slotCntNxt = slotCnt + 32'd1;
                        tickCntNxt = 32'd0;
                        lfsrNxt    = lfsrStep;
                        pmtNxt     = fireNext;
                        sentNxt    = sent + {31'd0, fireNext};
                        stateNxt   = fireNext ? HIGH : LOW;
                    end
                end else begin
                    tickCntNxt = tickCnt + 32'd1;
                    if ((state == HIGH) && (tickCnt + 32'd1 == widReg)) begin
                        pmtNxt   = 1'b0;
                        stateNxt = LOW;
                    end
                end
            end
            default: begin
                pmtNxt   = 1'b0;
                busyNxt  = 1'b0;
                stateNxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge wHClk_i) begin
        if (wRst_i) begin
            state   <= IDLE;
            slotCnt <= 32'd0;
            tickCnt <= 32'd0;
            numReg  <= 32'd0;
            perReg  <= 32'd0;
            widReg  <= 32'd0;
            randReg <= 1'b0;
            probReg <= 16'd0;
            lfsr    <= LFSR_SEED;
            pmt     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sent    <= 32'd0;
        end else begin
            state   <= stateNxt;
            slotCnt <= slotCntNxt;
            tickCnt <= tickCntNxt;
            numReg  <= numRegNxt;
            perReg  <= perRegNxt;
            widReg  <= widRegNxt;
            randReg <= randRegNxt;
            probReg <= probRegNxt;
            lfsr    <= lfsrNxt;
            pmt     <= pmtNxt;
            busy    <= busyNxt;
            done    <= doneNxt;
            sent    <= sentNxt;
        end
    end

    assign wPmt_o     = pmt;
    assign wBusy_o    = busy;
    assign wDone_o    = done;
    assign wSentCnt_o = sent;

endmodule

// File: tb/tb_pmt_pulse_gen.sv
// Self-checking bench for pmt_pulse_gen: per-cycle waveform comparison
// against a slot-arithmetic reference model.
module tb_pmt_pulse_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] num;
    logic [31:0] per;
    logic [7:0]  wid;
    logic        randEn;
    logic [15:0] prob;
    logic        pmt;
    logic        busy;
    logic        done;
    logic [31:0] sent;

    int passCnt  = 0;
    int totalCnt = 0;

    logic [15:0] mLfsr;
    longint      mSent;
    logic [63:0] obsVec;
    int          obsLen;
    logic [63:0] firstVec;

    always #5 clk = ~clk;

    pmt_pulse_gen #(.LFSR_SEED(16'hACE1)) dut (
        .wHClk_i     (clk),
        .wRst_i      (rst),
        .wStart_i    (start),
        .wAbort_i    (abort),
        .wPulseNum_i (num),
        .wPeriod_i   (per),
        .wWidth_i    (wid),
        .wRandEn_i   (randEn),
        .wProb_i     (prob),
        .wPmt_o      (pmt),
        .wBusy_o     (busy),
        .wDone_o     (done),
        .wSentCnt_o  (sent)
    );

    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // One burst, checked every cycle. abortAt=0 means no abort.
    task automatic runBurst(input longint nn, input longint pp,
                            input longint ww, input bit re,
                            input logic [15:0] pr, input bit noise,
                            input longint abortAt, input string tag);
        longint weff, peff, started, total, last, k, off, eSent, allSent;
        bit     fire[$];
        bit     ePmt, eBusy, eDone, inAbort;
        logic [34:0] obs, exp;
        weff = (ww == 0) ? 1 : ww;
        peff = (pp > weff) ? pp : weff + 1;
        started = nn;
        if (abortAt > 0) begin
            started = 0;
            while (started < nn && started * peff < abortAt) started++;
        end
        fire.delete();
        allSent = 0;
        for (longint j = 0; j < started; j++) begin
            bit f;
            f = !re || (mLfsr <= pr);
            fire.push_back(f);
            allSent += f ? 1 : 0;
            mLfsr = lfsrNext(mLfsr);
        end
        total = nn * peff;
        last  = (abortAt > 0) ? abortAt + 3 : total + 2;
        num    = nn[31:0];
        per    = pp[31:0];
        wid    = ww[7:0];
        randEn = re;
        prob   = pr;
        start  = 1'b1;
        abort  = 1'b0;
        obsVec = '0;
        obsLen = 0;
        @(posedge clk);
        for (longint c = 1; c <= last; c++) begin
            @(negedge clk);
            inAbort = (abortAt > 0) && (c > abortAt);
            k   = (c - 1) / peff;
            off = (c - 1) % peff;
            if (inAbort) begin
                ePmt = 0; eBusy = 0; eDone = 0; eSent = allSent;
            end else begin
                eBusy = (c <= total);
                eDone = (c == total + 1);
                ePmt  = eBusy ? (fire[k] && off < weff) : 1'b0;
                eSent = 0;
                for (longint j = 0; j < started && j <= k; j++)
                    eSent += fire[j] ? 1 : 0;
            end
            obs = {pmt, busy, done, sent};
            exp = {ePmt, eBusy, eDone, eSent[31:0]};
            totalCnt++;
            if (obs !== exp)
                $display("FAIL %s cycle %0d: got pmt=%b busy=%b done=%b sent=%0d, expected pmt=%b busy=%b done=%b sent=%0d",
                         tag, c, pmt, busy, done, sent, ePmt, eBusy, eDone, eSent);
            else
                passCnt++;
            if (!inAbort && eBusy && off == 0 && obsLen < 64) begin
                obsVec[obsLen] = pmt;
                obsLen++;
            end
            start = 1'b0;
            if (noise && c < total) begin
                start  = 1'($urandom);
                num    = $urandom;
                per    = $urandom;
                wid    = 8'($urandom);
                randEn = 1'($urandom);
                prob   = 16'($urandom);
            end
            abort = (abortAt > 0) && (c == abortAt);
        end
        start = 1'b0;
        abort = 1'b0;
        mSent = allSent;
    endtask

    // Idle-state checks for starts that must be ignored
    task automatic idleCheck(input string tag);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            totalCnt++;
            if ({pmt, busy, done, sent} !== {3'b000, mSent[31:0]})
                $display("FAIL %s cycle %0d: got pmt=%b busy=%b done=%b sent=%0d, expected 0 0 0 sent=%0d",
                         tag, c, pmt, busy, done, sent, mSent);
            else
                passCnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        totalCnt++;
        if ({pmt, busy, done, sent} !== 35'd0)
            $display("FAIL reset: got pmt=%b busy=%b done=%b sent=%0d, expected all 0",
                     pmt, busy, done, sent);
        else
            passCnt++;
        rst   = 1'b0;
        mLfsr = 16'hACE1;
        mSent = 0;
    endtask

    task automatic test_deterministic();
        runBurst(3, 10, 2, 1'b0, 16'h0, 1'b1, 0, "det_n3");
    endtask

    task automatic test_clamp();
        runBurst(4, 0, 0, 1'b0, 16'h0, 1'b0, 0, "clamp");
    endtask

    task automatic test_rand_extremes();
        runBurst(5, 8, 3, 1'b1, 16'h0000, 1'b0, 0, "prob0");
        runBurst(5, 8, 3, 1'b1, 16'hFFFF, 1'b0, 0, "probFFFF");
    endtask

    task automatic test_rand_sequence();
        test_reset();
        runBurst(16, 4, 1, 1'b1, 16'h8000, 1'b0, 0, "rand_seq1");
        firstVec = obsVec;
        runBurst(16, 4, 1, 1'b1, 16'h8000, 1'b0, 0, "rand_seq2");
        totalCnt++;
        if (obsVec[15:0] === firstVec[15:0])
            $display("FAIL rand_repeat: got second pattern %h, required different from %h",
                     obsVec[15:0], firstVec[15:0]);
        else
            passCnt++;
    endtask

    task automatic test_abort_and_ignored();
        runBurst(10, 6, 2, 1'b0, 16'h0, 1'b0, 14, "abort");
        num = 32'd0; per = 32'd5; wid = 8'd1; randEn = 1'b0;
        start = 1'b1;
        @(posedge clk);
        idleCheck("start_n0");
        num = 32'd3; start = 1'b1; abort = 1'b1;
        @(posedge clk);
        idleCheck("start_abort");
        runBurst(6, 5, 2, 1'b1, 16'h9000, 1'b0, 0, "after_ignored");
    endtask

    task automatic test_reset_mid_burst();
        bit seen;
        num = 32'd20; per = 32'd5; wid = 8'd2; randEn = 1'b0; prob = 16'h0;
        start = 1'b1;
        @(posedge clk);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            seen  = (pmt === 1'b1);
        end
        totalCnt++;
        if (!seen)
            $display("FAIL midrst_wait: got no pmt pulse in 50 cycles, required pmt=1");
        else
            passCnt++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        totalCnt++;
        if ({pmt, busy, done, sent} !== 35'd0)
            $display("FAIL midrst: got pmt=%b busy=%b done=%b sent=%0d, expected all 0",
                     pmt, busy, done, sent);
        else
            passCnt++;
        rst   = 1'b0;
        mLfsr = 16'hACE1;
        mSent = 0;
        runBurst(16, 4, 1, 1'b1, 16'h8000, 1'b0, 0, "post_rst_seq");
        totalCnt++;
        if (obsVec[15:0] !== firstVec[15:0])
            $display("FAIL post_rst_repeat: got pattern %h, required %h",
                     obsVec[15:0], firstVec[15:0]);
        else
            passCnt++;
    endtask

    task automatic test_random_bursts();
        for (int i = 0; i < 8; i++) begin
            runBurst(longint'($urandom_range(6, 1)),
                     longint'($urandom_range(12, 0)),
                     longint'($urandom_range(6, 0)),
                     1'($urandom), 16'($urandom),
                     1'($urandom), 0, "rand_burst");
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        num = '0; per = '0; wid = '0; randEn = 1'b0; prob = '0;
        mLfsr = 16'hACE1; mSent = 0; firstVec = '0;
        obsVec = '0; obsLen = 0;
        @(negedge clk);
        test_reset();
        test_deterministic();
        test_clamp();
        test_rand_extremes();
        test_rand_sequence();
        test_abort_and_ignored();
        test_reset_mid_burst();
        test_random_bursts();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
